// File: rtl/count_sequencer_pkg.sv
// Shared types and default sizes for the count sequencer slice.
package count_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_LOOPW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// Signal bundle for the count sequencer: control/config from the master, status back from the slave.
interface count_sequencer_if
  import count_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LOOPW = DEF_LOOPW
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] target;
  logic [LOOPW-1:0] loops;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             dir;
  logic             done;

  modport master (
    output start, abort, target, loops,
    input  q, busy, dir, done
  );

  modport slave (
    input  start, abort, target, loops,
    output q, busy, dir, done
  );

endinterface

// File: rtl/count_sequencer_updown_counter.sv
// Up/down counter datapath: clear has priority, then enable steps in the chosen direction.
module updown_counter
  import count_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      if (up) r_q <= r_q + 1'b1;
      else    r_q <= r_q - 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/count_sequencer.sv
// Triangle-wave count sequencer: (loops+1) ramps 0..target..0, then a one-cycle done pulse.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LOOPW = DEF_LOOPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] target,
  input  logic [LOOPW-1:0] loops,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             dir,
  output logic             done
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_target;
  logic [LOOPW-1:0] r_loop_cnt;
  logic [WIDTH-1:0] w_q_inc;
  logic [WIDTH-1:0] w_q_dec;
  logic             w_clr;
  logic             w_en;
  logic             w_up;

  assign w_q_inc = q + 1'b1;
  assign w_q_dec = q - 1'b1;

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .up    (w_up),
    .q     (q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_target   <= '0;
      r_loop_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (!abort) begin
        if (r_state == ST_IDLE && start) begin
          r_target   <= target;
          r_loop_cnt <= loops;
        end else if (r_state == ST_DOWN && w_q_dec == '0 && r_loop_cnt != '0) begin
          r_loop_cnt <= r_loop_cnt - 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next_state = (target == '0) ? ST_DONE : ST_UP;
      ST_UP:   if (w_q_inc == r_target) w_next_state = ST_DOWN;
      ST_DOWN: if (w_q_dec == '0) w_next_state = (r_loop_cnt == '0) ? ST_DONE : ST_UP;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (abort) w_next_state = ST_IDLE;
  end

  // Status decodes only registered state; counter controls may also see start/abort.
  always_comb begin
    busy  = 1'b0;
    dir   = 1'b0;
    done  = 1'b0;
    w_clr = 1'b0;
    w_en  = 1'b0;
    w_up  = 1'b0;
    unique case (r_state)
      ST_IDLE: w_clr = start;
      ST_UP: begin
        busy = 1'b1;
        dir  = 1'b1;
        w_en = 1'b1;
        w_up = 1'b1;
      end
      ST_DOWN: begin
        busy = 1'b1;
        w_en = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    if (abort) w_clr = 1'b1;
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed, table-driven bench for count_sequencer with hand-written corner sequences.
module tb_count_sequencer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned LOOPW = 3;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  count_sequencer_if #(.WIDTH(WIDTH), .LOOPW(LOOPW)) u_if ();

  count_sequencer #(
    .WIDTH (WIDTH),
    .LOOPW (LOOPW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (u_if.start),
    .abort  (u_if.abort),
    .target (u_if.target),
    .loops  (u_if.loops),
    .q      (u_if.q),
    .busy   (u_if.busy),
    .dir    (u_if.dir),
    .done   (u_if.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    int lps;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent triangle model: position p within a 2T-cycle triangle.
  function automatic int exp_q(input int t, input int k);
    int p;
    p = k % (2 * t);
    return (p < t) ? p : 2 * t - p;
  endfunction

  function automatic int exp_dir(input int t, input int k);
    return ((k % (2 * t)) < t) ? 1 : 0;
  endfunction

  task automatic run_vec(input int t, input int l);
    u_if.target = t[WIDTH-1:0];
    u_if.loops  = l[LOOPW-1:0];
    u_if.start  = 1'b1;
    tick();
    u_if.start  = 1'b0;
    if (t == 0) begin
      check("t0_done", int'(u_if.done), 1);
      check("t0_busy", int'(u_if.busy), 0);
      check("t0_q", int'(u_if.q), 0);
    end else begin
      for (int k = 0; k < (l + 1) * 2 * t; k++) begin
        check("busy", int'(u_if.busy), 1);
        check("q", int'(u_if.q), exp_q(t, k));
        check("dir", int'(u_if.dir), exp_dir(t, k));
        check("done_early", int'(u_if.done), 0);
        tick();
      end
      check("end_busy", int'(u_if.busy), 0);
      check("end_done", int'(u_if.done), 1);
      check("end_q", int'(u_if.q), 0);
    end
    tick();
    check("post_done", int'(u_if.done), 0);
    check("post_busy", int'(u_if.busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{3, 0};
    vecs[1] = '{1, 0};
    vecs[2] = '{2, 2};
    vecs[3] = '{15, 1};
    vecs[4] = '{0, 5};
    vecs[5] = '{15, 0};
    vecs[6] = '{5, 3};

    u_if.start  = 1'b0;
    u_if.abort  = 1'b0;
    u_if.target = '0;
    u_if.loops  = '0;
    reset = 1'b1;
    #1;
    check("rst_q", int'(u_if.q), 0);
    check("rst_busy", int'(u_if.busy), 0);
    check("rst_dir", int'(u_if.dir), 0);
    check("rst_done", int'(u_if.done), 0);
    #22;
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i].tgt, vecs[i].lps);

    // Abort at q=5 while ramping up, with a simultaneous start.
    u_if.target = 4'd9;
    u_if.loops  = 3'd0;
    u_if.start  = 1'b1;
    tick();
    u_if.start  = 1'b0;
    repeat (5) tick();
    check("ab_q5", int'(u_if.q), 5);
    check("ab_dir", int'(u_if.dir), 1);
    u_if.abort = 1'b1;
    u_if.start = 1'b1;
    tick();
    u_if.abort = 1'b0;
    u_if.start = 1'b0;
    check("ab_q", int'(u_if.q), 0);
    check("ab_busy", int'(u_if.busy), 0);
    check("ab_done", int'(u_if.done), 0);
    for (int k = 0; k < 12; k++) begin
      check("ab_nodone", int'(u_if.done), 0);
      check("ab_idle", int'(u_if.busy), 0);
      tick();
    end

    // Abort beats start in IDLE.
    u_if.abort = 1'b1;
    u_if.start = 1'b1;
    tick();
    u_if.abort = 1'b0;
    u_if.start = 1'b0;
    check("abst_busy", int'(u_if.busy), 0);
    check("abst_done", int'(u_if.done), 0);
    tick();
    check("abst_busy2", int'(u_if.busy), 0);

    // start/target/loops changes while busy are ignored.
    u_if.target = 4'd2;
    u_if.loops  = 3'd0;
    u_if.start  = 1'b1;
    tick();
    u_if.target = 4'd9;
    u_if.loops  = 3'd3;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) u_if.start = 1'b0;
      check("ign_busy", int'(u_if.busy), 1);
      check("ign_q", int'(u_if.q), exp_q(2, k));
      tick();
    end
    check("ign_done", int'(u_if.done), 1);
    tick();
    check("ign_idle", int'(u_if.busy), 0);
    tick();
    check("ign_stay", int'(u_if.busy), 0);

    // start held across DONE relaunches after one IDLE cycle.
    u_if.target = 4'd1;
    u_if.loops  = 3'd0;
    u_if.start  = 1'b1;
    tick();
    check("hold_up", int'(u_if.dir), 1);
    tick();
    check("hold_q1", int'(u_if.q), 1);
    tick();
    check("hold_done", int'(u_if.done), 1);
    tick();
    check("hold_idle", int'(u_if.busy), 0);
    check("hold_idle_done", int'(u_if.done), 0);
    tick();
    check("hold_relaunch", int'(u_if.busy), 1);
    u_if.start = 1'b0;
    tick();
    check("hold_down", int'(u_if.q), 1);
    tick();
    check("hold_done2", int'(u_if.done), 1);
    tick();

    // Asynchronous reset mid-DOWN.
    u_if.target = 4'd4;
    u_if.loops  = 3'd0;
    u_if.start  = 1'b1;
    tick();
    u_if.start  = 1'b0;
    repeat (5) tick();
    check("rd_q", int'(u_if.q), 3);
    check("rd_dir", int'(u_if.dir), 0);
    #2;
    reset = 1'b1;
    #1;
    check("rd_rst_q", int'(u_if.q), 0);
    check("rd_rst_busy", int'(u_if.busy), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      check("rd_nodone", int'(u_if.done), 0);
      check("rd_idle", int'(u_if.busy), 0);
      tick();
    end
    run_vec(3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
